ps2_device_tx: RTL and testbench
================================

// Module: ps2_device_tx
// PURPOSE
//  Device-side PS/2 transmitter, the keyboard end of the PS/2 link that the chipset's host
//  keyboard controller receives on. It generates the PS/2 clock and serialises queued bytes
//  as 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
//  It sits beside the top level to emulate a keyboard, for example for a UART-to-scancode
//  bridge or a bench driver, and drives the open-drain clkps2/dataps2 pins.
//  Outputs are drive-low enables: 0 pulls the line low, 1 releases it.
// PARAMETERS
//  HALF_PERIOD  2000  clock cycles per PS/2 clock phase, high or low (2000 cycles = 40 us at 50 MHz)
//  IDLE_WAIT    2500  consecutive cycles with both lines high that are required before a frame starts
//  FIFO_DEPTH   4     transmit queue entries; must be a power of 2
// PORTS
//  clock        in   1   system clock
//  reset_n      in   1   synchronous, active-low reset
//  tx_data      in   8   byte to queue
//  tx_valid     in   1   push request; the byte is accepted when tx_valid & tx_ready
//  tx_ready     out  1   registered; 1 while the FIFO is not full
//  ps2_clk_in   in   1   sampled PS/2 clock line (asynchronous; 2-FF synchronised inside)
//  ps2_dat_in   in   1   sampled PS/2 data line (asynchronous; 2-FF synchronised inside)
//  ps2_clk_out  out  1   0 = drive the clock line low, 1 = release it
//  ps2_dat_out  out  1   0 = drive the data line low, 1 = release it
//  busy         out  1   1 while a frame is on the wire (BIT_HIGH, BIT_LOW or RECOVER)
//  abort        out  1   one-cycle pulse when the host inhibits a frame
//  host_rts     out  1   1 while the host holds data low with clock high (request-to-send)
//  fifo_count   out  log2(FIFO_DEPTH)+1   number of queued bytes
// BEHAVIOUR
//  Reset (reset_n=0 at a clock edge): ps2_clk_out=1, ps2_dat_out=1, busy=0, abort=0, host_rts=0,
//   fifo_count=0, tx_ready=0. The FIFO is flushed and the state goes to IDLE.
//   tx_ready rises the cycle after reset_n goes high.
//  Reset asserted mid-frame releases both lines at the next edge; no abort pulse is issued.
//  FIFO: push when tx_valid & tx_ready. tx_ready comes from the registered count, so a push while
//   full is ignored even if a pop happens in the same cycle. The head entry is popped only when
//   its frame completes, never on abort.
//  idle_cnt: counts cycles with synchronised clk=1 & dat=1 and saturates at IDLE_WAIT.
//   Any low sample clears it. It also counts while the block itself releases the lines.
//  States:
//   IDLE      lines released. If fifo_count>0 & idle_cnt==IDLE_WAIT & !host_rts: load shift reg
//             {1, ~^head, head, 0}, set bit index 0, go to BIT_HIGH with ps2_dat_out=0 (start bit).
//   BIT_HIGH  ps2_clk_out=1 and ps2_dat_out=current bit, both held HALF_PERIOD cycles.
//             If synchronised clk reads 0 while bit index<=9: abort.
//             Otherwise go to BIT_LOW and drive ps2_clk_out=0 (host samples on this falling edge).
//   BIT_LOW   ps2_clk_out=0 for HALF_PERIOD cycles, data unchanged. Then increment the bit index.
//             If index<=10, go to BIT_HIGH and present the next bit in the same cycle as the
//             clock rises. After the 11th low phase (stop bit), pop the FIFO and go to RECOVER.
//   RECOVER   lines released for HALF_PERIOD cycles, then go to IDLE.
//  Abort: both lines released at the next edge, abort pulses for 1 cycle, and the state goes to
//   IDLE. The same byte is retransmitted from the start once idle_cnt reaches IDLE_WAIT again.
//   Inhibit is not checked during BIT_LOW (the block drives clock low), at index 10, or in RECOVER.
//  host_rts = sync clk & ~sync dat while in IDLE. It blocks frame starts; host commands are not
//   received and remain the host's responsibility to retry.
//  Parity is odd: parity bit = ~^data.
//  Frame timing: 11 falling edges, 2*HALF_PERIOD cycles apart. The first falling edge comes
//   HALF_PERIOD cycles after the start bit is driven.
// TESTING (bench: HALF_PERIOD=4, IDLE_WAIT=8, lines pulled up in the bench)
//  1. Bus idle >8 cycles, push 0x1C -> data sampled at the falling edges is 0,0,0,1,1,1,0,0,0,0,1
//     (parity 0); falling edges 8 cycles apart; fifo_count 1->0 at the end of the stop low phase;
//     busy high throughout.
//  2. Push 0x00 -> parity bit 1; push 0xFF -> parity bit 1; push 0x01 -> parity bit 0.
//  3. Push 0x1C; bench pulls clk low during the BIT_HIGH of index 4 -> abort pulses once, both
//     outputs =1 next cycle, fifo_count stays 1; after release and 8 idle cycles the full 0x1C
//     frame is sent again.
//  4. Hold clk low; push 0xF0,0x1C,0xE0,0x75 -> tx_ready=0, fifo_count=4; a 5th push of 0xAA is
//     dropped; release -> the four frames go out in order with a RECOVER gap between them;
//     0xAA never appears.
//  5. reset_n=0 during the BIT_LOW of index 6 -> next edge ps2_clk_out=1, ps2_dat_out=1,
//     fifo_count=0, abort=0; tx_ready=1 one cycle after reset_n=1.
//  6. Bench holds dat low with clk high and pushes 0x5A -> host_rts=1, no frame starts;
//     release dat -> frame 0x5A starts 8 cycles later.

Source files
------------

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: generates the PS/2 clock and sends queued bytes as
// 11-bit frames (start, 8 data LSB first, odd parity, stop) on open-drain drive-low enables.
module ps2_device_tx #(
    parameter int HALF_PERIOD = 2000,
    parameter int IDLE_WAIT   = 2500,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          ps2_clk_in,
    input  logic                          ps2_dat_in,
    output logic                          ps2_clk_out,
    output logic                          ps2_dat_out,
    output logic                          busy,
    output logic                          abort,
    output logic                          host_rts,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(IDLE_WAIT + 1);
    localparam int TW = $clog2(HALF_PERIOD + 1);
    localparam logic [CW-1:0] IDLE_MAX  = CW'(IDLE_WAIT);
    localparam logic [TW-1:0] PHASE_END = TW'(HALF_PERIOD - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BIT_HIGH, BIT_LOW, RECOVER} state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [3:0]      bit_idx;
    logic [10:0]     shift;
    logic [CW-1:0]   idle_cnt;
    logic            clk_p0, clk_p1, dat_p0, dat_p1;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count_next;
    logic [7:0]      head;
    logic            push, pop, start, rts_now;

    // stage p0/p1: two-flop synchronisers for the asynchronous line samples
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clk_p0 <= 1'b1;
            clk_p1 <= 1'b1;
            dat_p0 <= 1'b1;
            dat_p1 <= 1'b1;
        end else begin
            clk_p0 <= ps2_clk_in;
            clk_p1 <= clk_p0;
            dat_p0 <= ps2_dat_in;
            dat_p1 <= dat_p0;
        end
    end

    assign rts_now = clk_p1 & ~dat_p1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (!(clk_p1 & dat_p1)) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Ready is registered from the count, so a full FIFO refuses a push even on a pop cycle.
    assign push       = tx_valid & tx_ready;
    assign pop        = (state == BIT_LOW) && (timer == PHASE_END) && (bit_idx == 4'd10);
    assign count_next = fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign head       = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tx_ready   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= count_next;
            tx_ready   <= (count_next != FULL);
        end
    end

    assign start = (state == IDLE) && (fifo_count != '0) && (idle_cnt == IDLE_MAX) && !rts_now;

    always_ff @(posedge clock) begin
        if (start) begin
            shift <= {1'b1, ~^head, head, 1'b0};
        end
    end

    // Inhibit is judged on the last cycle of the high phase, after the released clock
    // has had time to propagate through the synchroniser.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            ps2_clk_out <= 1'b1;
            ps2_dat_out <= 1'b1;
            busy        <= 1'b0;
            abort       <= 1'b0;
            host_rts    <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    ps2_clk_out <= 1'b1;
                    ps2_dat_out <= 1'b1;
                    busy        <= 1'b0;
                    host_rts    <= rts_now;
                    timer       <= '0;
                    if (start) begin
                        bit_idx     <= '0;
                        ps2_dat_out <= 1'b0;
                        busy        <= 1'b1;
                        state       <= BIT_HIGH;
                    end
                end
                BIT_HIGH: begin
                    host_rts <= 1'b0;
                    if (timer == PHASE_END) begin
                        timer <= '0;
                        if (!clk_p1 && bit_idx <= 4'd9) begin
                            ps2_clk_out <= 1'b1;
                            ps2_dat_out <= 1'b1;
                            abort       <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            ps2_clk_out <= 1'b0;
                            state       <= BIT_LOW;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BIT_LOW: begin
                    host_rts <= 1'b0;
                    if (timer == PHASE_END) begin
                        timer       <= '0;
                        ps2_clk_out <= 1'b1;
                        if (bit_idx == 4'd10) begin
                            ps2_dat_out <= 1'b1;
                            state       <= RECOVER;
                        end else begin
                            bit_idx     <= bit_idx + 4'd1;
                            ps2_dat_out <= shift[bit_idx + 4'd1];
                            state       <= BIT_HIGH;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RECOVER: begin
                    host_rts    <= 1'b0;
                    ps2_clk_out <= 1'b1;
                    ps2_dat_out <= 1'b1;
                    if (timer == PHASE_END) begin
                        timer <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: pulled-up open-drain lines, a host that can inhibit or request
// to send, and a scoreboard of queued bytes checked against frames captured at falling edges.
module tb_ps2_device_tx;

    localparam int HP = 4;
    localparam int IW = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_out, ps2_dat_out;
    logic       busy, abort, host_rts;
    logic [2:0] fifo_count;
    logic       host_clk = 1'b1;
    logic       host_dat = 1'b1;

    int total = 0;
    int bad = 0;

    logic [7:0]  sb [$];
    logic [10:0] got_q [$];
    int          frames_done = 0;

    assign ps2_clk_in = ps2_clk_out & host_clk;
    assign ps2_dat_in = ps2_dat_out & host_dat;

    always #5 clock = ~clock;

    ps2_device_tx #(.HALF_PERIOD(HP), .IDLE_WAIT(IW), .FIFO_DEPTH(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_dat_in  (ps2_dat_in),
        .ps2_clk_out (ps2_clk_out),
        .ps2_dat_out (ps2_dat_out),
        .busy        (busy),
        .abort       (abort),
        .host_rts    (host_rts),
        .fifo_count  (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Frame capture on the device's own falling clock edges
    int          cyc = 0;
    int          bit_n = 0;
    int          last_edge = 0;
    int          last_end = 0;
    bit          end_vld = 1'b0;
    logic        prev_clk = 1'b1;
    logic [2:0]  prev_cnt = '0;
    logic [10:0] frame = '0;
    logic [7:0]  exp_b;

    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            bit_n    = 0;
            prev_clk = 1'b1;
            prev_cnt = '0;
            end_vld  = 1'b0;
        end else begin
            if (abort) begin
                bit_n   = 0;
                end_vld = 1'b0;
            end
            if (prev_clk && !ps2_clk_out) begin
                chk("busy_at_edge", busy, 1);
                if (bit_n > 0)
                    chk("edge_spacing", cyc - last_edge, 2 * HP);
                else if (end_vld)
                    chk("recover_gap", (cyc - last_end) >= 16, 1);
                last_edge    = cyc;
                frame[bit_n] = ps2_dat_in;
                bit_n++;
                if (bit_n == 11) begin
                    bit_n = 0;
                    got_q.push_back(frame);
                    frames_done++;
                    last_end = cyc;
                    end_vld  = 1'b1;
                    chk("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        exp_b = sb.pop_front();
                        chk("frame", frame, make_frame(exp_b));
                    end
                end
            end
            if (fifo_count == prev_cnt - 1)
                chk("pop_timing", cyc - last_edge, HP);
            prev_clk = ps2_clk_out;
            prev_cnt = fifo_count;
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic want_acc, input string tag);
        logic acc;
        @(negedge clock);
        tx_data  = b;
        tx_valid = 1'b1;
        acc      = tx_ready;
        if (acc) sb.push_back(b);
        chk(tag, acc, want_acc);
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tag, frames_done >= target, 1);
    endtask

    initial begin
        int n;
        int aborts;
        bit found;
        logic clk_at_abort, dat_at_abort;
        logic [2:0] cnt_at_abort;

        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        cyc_wait(3);
        chk("rst_clk_out", ps2_clk_out, 1);
        chk("rst_dat_out", ps2_dat_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_abort", abort, 0);
        chk("rst_rts", host_rts, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", tx_ready, 0);
        reset_n = 1'b1;
        cyc_wait(1);
        chk("ready_after_rst", tx_ready, 1);

        // single frame on an idle bus
        cyc_wait(12);
        push_byte(8'h1C, 1'b1, "push_1c");
        chk("count_one", fifo_count, 1);
        wait_frames(1, 400, "t1_done");
        chk("t1_frame", got_q[0], 11'b10000111000);
        cyc_wait(10);
        chk("t1_empty", fifo_count, 0);

        // parity corner bytes
        push_byte(8'h00, 1'b1, "push_00");
        push_byte(8'hFF, 1'b1, "push_ff");
        push_byte(8'h01, 1'b1, "push_01");
        wait_frames(4, 1200, "t2_done");
        chk("t2_frame00", got_q[1], 11'b11000000000);
        chk("t2_frameff", got_q[2], 11'b11111111110);
        chk("t2_frame01", got_q[3], 11'b10000000010);
        cyc_wait(10);

        // host inhibit during the high phase of bit index 4
        push_byte(8'h1C, 1'b1, "push_1c_abort");
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clock);
            if (bit_n == 4 && ps2_clk_out) found = 1'b1;
        end
        chk("t3_reach_idx4", found, 1);
        host_clk = 1'b0;
        aborts = 0;
        clk_at_abort = 1'b0;
        dat_at_abort = 1'b0;
        cnt_at_abort = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (abort) begin
                aborts++;
                clk_at_abort = ps2_clk_out;
                dat_at_abort = ps2_dat_out;
                cnt_at_abort = fifo_count;
            end
        end
        chk("t3_abort_pulses", aborts, 1);
        chk("t3_clk_released", clk_at_abort, 1);
        chk("t3_dat_released", dat_at_abort, 1);
        chk("t3_count_kept", cnt_at_abort, 1);
        chk("t3_busy_low", busy, 0);
        host_clk = 1'b1;
        wait_frames(5, 400, "t3_retx");
        chk("t3_frame", got_q[4], 11'b10000111000);
        cyc_wait(10);

        // fill the FIFO while the host holds the clock low
        host_clk = 1'b0;
        cyc_wait(2);
        push_byte(8'hF0, 1'b1, "push_f0");
        push_byte(8'h1C, 1'b1, "push_1c_q");
        push_byte(8'hE0, 1'b1, "push_e0");
        push_byte(8'h75, 1'b1, "push_75");
        chk("t4_full_ready", tx_ready, 0);
        chk("t4_full_count", fifo_count, 4);
        push_byte(8'hAA, 1'b0, "push_aa_dropped");
        chk("t4_still_full", fifo_count, 4);
        chk("t4_not_busy", busy, 0);
        host_clk = 1'b1;
        wait_frames(9, 1500, "t4_done");
        cyc_wait(60);
        chk("t4_no_extra", frames_done, 9);
        chk("t4_sb_empty", sb.size(), 0);

        // reset in the low phase of bit index 6
        push_byte(8'h3C, 1'b1, "push_3c");
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clock);
            if (bit_n == 7 && !ps2_clk_out) found = 1'b1;
        end
        chk("t5_reach_idx6", found, 1);
        reset_n = 1'b0;
        sb.delete();
        cyc_wait(1);
        chk("t5_clk_out", ps2_clk_out, 1);
        chk("t5_dat_out", ps2_dat_out, 1);
        chk("t5_count", fifo_count, 0);
        chk("t5_abort", abort, 0);
        chk("t5_busy", busy, 0);
        cyc_wait(1);
        chk("t5_ready_in_rst", tx_ready, 0);
        reset_n = 1'b1;
        cyc_wait(1);
        chk("t5_ready_after", tx_ready, 1);
        cyc_wait(40);
        chk("t5_no_frame", frames_done, 9);

        // host request-to-send blocks the start
        host_dat = 1'b0;
        cyc_wait(3);
        push_byte(8'h5A, 1'b1, "push_5a");
        cyc_wait(20);
        chk("t6_rts", host_rts, 1);
        chk("t6_not_busy", busy, 0);
        chk("t6_count", fifo_count, 1);
        chk("t6_dat_released", ps2_dat_out, 1);
        host_dat = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            n++;
            if (!ps2_dat_out) break;
        end
        // two synchroniser stages, IW idle cycles, then the cycle that launches the start bit
        chk("t6_start_delay", n, 2 + IW + 1);
        chk("t6_rts_clear", host_rts, 0);
        wait_frames(10, 400, "t6_done");
        chk("t6_frame", got_q[9], make_frame(8'h5A));
        cyc_wait(20);
        chk("end_frames", got_q.size(), 10);
        chk("end_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
